vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator. It merges the pixel clock-enable divider, the x/y position counters and the hsync/vsync/blank decode into one block.
- All outputs are mutually aligned on the same CLK_40 edge, so downstream pixel fetch needs no per-signal skew compensation.
- Adds what the current blocks lack:
  - programmable sync polarity
  - an enable/pause input
  - line_start and frame_start strobes
  - correct first-frame behaviour after reset
- Sits between the system clock and the frame-buffer reader / VGA DAC outputs.

---
 rtl/vga_timing_pkg.sv | 49 ++++
 rtl/pix_en_div.sv | 34 +++
 rtl/vga_timing_gen.sv | 104 ++++++++++
 tb/tb_vga_timing_gen.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing definitions: 640x480@60 defaults, per-axis timing
// record and helpers that derive totals and sync windows from it.
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
  } vga_axis_t;

  typedef struct packed {
    vga_axis_t h;
    vga_axis_t v;
  } vga_timing_t;

  function automatic vga_axis_t make_axis(input int active, input int fp,
                                          input int sync, input int bp);
    vga_axis_t a;
    a.active = 16'(active);
    a.fp     = 16'(fp);
    a.sync   = 16'(sync);
    a.bp     = 16'(bp);
    return a;
  endfunction

  function automatic int axis_total(input vga_axis_t a);
    return int'(a.active) + int'(a.fp) + int'(a.sync) + int'(a.bp);
  endfunction

  function automatic int sync_start(input vga_axis_t a);
    return int'(a.active) + int'(a.fp);
  endfunction

  // Half-open window [start, start+len), evaluated in 32-bit arithmetic.
  function automatic logic in_window(input int pos, input int start, input int len);
    return (pos >= start) && (pos < start + len);
  endfunction

endpackage

// File: rtl/pix_en_div.sv
// Clock-enable divider: one-cycle strobe every DIV enabled cycles, registered.
// Enable low holds the phase and forces the strobe low; resuming keeps phase.
module pix_en_div #(
  parameter int DIV = 4,
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic strobe
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      strobe <= 1'b0;
    end else if (enable) begin
      if (cnt == CNT_LAST) begin
        cnt    <= '0;
        strobe <= 1'b1;
      end else begin
        cnt    <= cnt + CNT_W'(1);
        strobe <= 1'b0;
      end
    end else begin
      strobe <= 1'b0;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: position, sync/blank decode and strobes all registered
// together, one cycle after each pixel strobe; enable low freezes everything.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int H_ACTIVE  = VGA_H_ACTIVE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_ACTIVE  = VGA_V_ACTIVE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  localparam vga_timing_t TIMING = '{h: make_axis(H_ACTIVE, H_FP, H_SYNC, H_BP),
                                     v: make_axis(V_ACTIVE, V_FP, V_SYNC, V_BP)},
  localparam int H_TOTAL  = axis_total(TIMING.h),
  localparam int V_TOTAL  = axis_total(TIMING.v),
  localparam int X_W      = $clog2(H_TOTAL),
  localparam int Y_W      = $clog2(V_TOTAL)
) (
  input  logic           CLK_40,
  input  logic           reset,
  input  logic           enable,
  output logic           pix_en,
  output logic [X_W-1:0] x_pos,
  output logic [Y_W-1:0] y_pos,
  output logic           hsync,
  output logic           vsync,
  output logic           active,
  output logic           line_start,
  output logic           frame_start
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_TOTAL - 1);
  localparam int HS_START = sync_start(TIMING.h);
  localparam int VS_START = sync_start(TIMING.v);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t         state;
  logic [X_W-1:0] nx;
  logic [Y_W-1:0] ny;
  logic           hs_on;
  logic           vs_on;
  logic           act_on;

  pix_en_div #(.DIV(CLK_DIV)) u_pix_en_div (
    .clk    (CLK_40),
    .reset  (reset),
    .enable (enable),
    .strobe (pix_en)
  );

  // IDLE presents (0,0) on its first advance so the first displayed pixel is the origin.
  always_comb begin
    nx = x_pos;
    ny = y_pos;
    if (state == ST_IDLE) begin
      nx = '0;
      ny = '0;
    end else if (x_pos != X_LAST) begin
      nx = x_pos + X_W'(1);
    end else begin
      nx = '0;
      ny = (y_pos == Y_LAST) ? '0 : y_pos + Y_W'(1);
    end
  end

  always_comb begin
    hs_on  = in_window(int'(nx), HS_START, H_SYNC);
    vs_on  = in_window(int'(ny), VS_START, V_SYNC);
    act_on = (int'(nx) < H_ACTIVE) && (int'(ny) < V_ACTIVE);
  end

  always_ff @(posedge CLK_40 or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      x_pos       <= '0;
      y_pos       <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      active      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (enable && pix_en) begin
      state       <= ST_RUN;
      x_pos       <= nx;
      y_pos       <= ny;
      hsync       <= hs_on ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= vs_on ? VSYNC_POL : ~VSYNC_POL;
      active      <= act_on;
      line_start  <= (nx == '0);
      frame_start <= (nx == '0) && (ny == '0);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Two instances (CLK_DIV=2 active-low syncs, CLK_DIV=1 active-high syncs) on a
// 15x8 raster, compared every cycle against a pixel-index reference model.
module tb_vga_timing_gen;

  localparam int HT    = 15;
  localparam int VT    = 8;
  localparam int FRAME = HT * VT;

  logic       CLK_40 = 1'b0;
  logic       reset;
  logic       enable;

  logic       a_pe, a_hs, a_vs, a_act, a_ls, a_fs;
  logic [3:0] a_x;
  logic [2:0] a_y;
  logic       b_pe, b_hs, b_vs, b_act, b_ls, b_fs;
  logic [3:0] b_x;
  logic [2:0] b_y;

  always #5 CLK_40 = ~CLK_40;

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut_a (
    .CLK_40(CLK_40), .reset(reset), .enable(enable), .pix_en(a_pe),
    .x_pos(a_x), .y_pos(a_y), .hsync(a_hs), .vsync(a_vs), .active(a_act),
    .line_start(a_ls), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut_b (
    .CLK_40(CLK_40), .reset(reset), .enable(enable), .pix_en(b_pe),
    .x_pos(b_x), .y_pos(b_y), .hsync(b_hs), .vsync(b_vs), .active(b_act),
    .line_start(b_ls), .frame_start(b_fs)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: count enabled cycles and advances; position is a pixel index.
  int m_div[2] = '{2, 1};
  bit m_pol[2] = '{1'b0, 1'b1};
  int m_ecnt[2];
  int m_nadv[2];
  bit m_pe[2];
  bit m_adv[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ecnt[i] = 0;
      m_nadv[i] = 0;
      m_pe[i]   = 1'b0;
      m_adv[i]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_adv[i] = enable && m_pe[i];
        if (m_adv[i]) m_nadv[i]++;
        if (enable) begin
          m_ecnt[i]++;
          m_pe[i] = (m_ecnt[i] % m_div[i]) == 0;
        end else begin
          m_pe[i] = 1'b0;
        end
      end
    end
  endtask

  function automatic int mx(input int i);
    return (m_nadv[i] == 0) ? 0 : ((m_nadv[i] - 1) % FRAME) % HT;
  endfunction

  function automatic int my(input int i);
    return (m_nadv[i] == 0) ? 0 : ((m_nadv[i] - 1) % FRAME) / HT;
  endfunction

  task automatic check_inst(input int i, input logic pe, input logic [3:0] x,
                            input logic [2:0] y, input logic hs, input logic vs,
                            input logic act, input logic ls, input logic fs);
    string p;
    int    ex, ey;
    bit    idle, e_hs, e_vs, e_act, e_ls, e_fs;
    p     = (i == 0) ? "A" : "B";
    ex    = mx(i);
    ey    = my(i);
    idle  = (m_nadv[i] == 0);
    e_hs  = (!idle && ex >= 10 && ex < 13) ? m_pol[i] : ~m_pol[i];
    e_vs  = (!idle && ey >= 5 && ey < 7) ? m_pol[i] : ~m_pol[i];
    e_act = !idle && ex < 8 && ey < 4;
    e_ls  = m_adv[i] && ex == 0;
    e_fs  = m_adv[i] && ex == 0 && ey == 0;
    check_val({p, ".pix_en"}, pe, m_pe[i]);
    check_val({p, ".x_pos"}, x, ex);
    check_val({p, ".y_pos"}, y, ey);
    check_val({p, ".hsync"}, hs, e_hs);
    check_val({p, ".vsync"}, vs, e_vs);
    check_val({p, ".active"}, act, e_act);
    check_val({p, ".line_start"}, ls, e_ls);
    check_val({p, ".frame_start"}, fs, e_fs);
  endtask

  task automatic check_all();
    check_inst(0, a_pe, a_x, a_y, a_hs, a_vs, a_act, a_ls, a_fs);
    check_inst(1, b_pe, b_x, b_y, b_hs, b_vs, b_act, b_ls, b_fs);
  endtask

  task automatic step();
    @(posedge CLK_40);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, ".a_x"}, a_x, 0);
    check_val({tag, ".a_y"}, a_y, 0);
    check_val({tag, ".a_pe"}, a_pe, 0);
    check_val({tag, ".a_hs"}, a_hs, 1);
    check_val({tag, ".a_vs"}, a_vs, 1);
    check_val({tag, ".a_act"}, a_act, 0);
    check_val({tag, ".a_fs"}, a_fs, 0);
    check_val({tag, ".b_hs"}, b_hs, 0);
    check_val({tag, ".b_vs"}, b_vs, 0);
  endtask

  // Called at #1 after an edge with reset just released and enable high.
  task automatic first_frame(input string tag);
    step();
    check_val({tag, ".pe_c1"}, a_pe, 0);
    check_val({tag, ".b_pe_c1"}, b_pe, 1);
    step();
    check_val({tag, ".pe_c2"}, a_pe, 1);
    check_val({tag, ".fs_c2"}, a_fs, 0);
    check_val({tag, ".b_fs_c2"}, b_fs, 1);
    step();
    check_val({tag, ".x_c3"}, a_x, 0);
    check_val({tag, ".y_c3"}, a_y, 0);
    check_val({tag, ".fs_c3"}, a_fs, 1);
    check_val({tag, ".ls_c3"}, a_ls, 1);
    check_val({tag, ".act_c3"}, a_act, 1);
    check_val({tag, ".b_x_c3"}, b_x, 1);
    step();
    check_val({tag, ".pe_c4"}, a_pe, 1);
    step();
    check_val({tag, ".x_c5"}, a_x, 1);
    check_val({tag, ".fs_c5"}, a_fs, 0);
  endtask

  initial begin
    int fs_seen;
    int pe_cnt;
    bit found;

    reset  = 1'b1;
    enable = 1'b0;
    model_reset();
    step();
    step();
    check_reset_vals("reset");

    reset  = 1'b0;
    enable = 1'b1;
    first_frame("boot");

    // Free run; frame period measured in pixel strobes between frame_start.
    fs_seen = 0;
    pe_cnt  = 0;
    for (int k = 0; k < 520; k++) begin
      step();
      if (a_fs) begin
        if (fs_seen > 0) check_val("frame_period", pe_cnt, FRAME);
        fs_seen++;
        pe_cnt = 0;
      end else if (a_pe) begin
        pe_cnt++;
      end
    end
    check_val("frames_seen", (fs_seen >= 2) ? 1 : 0, 1);

    // Pause right after reaching x=5.
    found = 1'b0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (m_adv[0] && mx(0) == 5) begin
        found = 1'b1;
        break;
      end
    end
    check_val("pause.reach_x5", found, 1);
    enable = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      check_val("pause.x_hold", a_x, 5);
      check_val("pause.pe_low", a_pe, 0);
      check_val("pause.hs_hold", a_hs, 1);
    end
    enable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (a_x != 4'd5) break;
    end
    check_val("pause.resume_x", a_x, 6);

    // Randomised run/pause traffic.
    for (int k = 0; k < 2500; k++) begin
      enable = ($urandom_range(0, 3) != 0);
      step();
    end

    // Asynchronous reset at (9,3).
    enable = 1'b1;
    found  = 1'b0;
    for (int k = 0; k < 600; k++) begin
      step();
      if (m_nadv[0] > 0 && mx(0) == 9 && my(0) == 3) begin
        found = 1'b1;
        break;
      end
    end
    check_val("midreset.reach", found, 1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_reset_vals("midreset");
    check_all();
    step();
    reset = 1'b0;
    first_frame("rerun");
    for (int k = 0; k < 300; k++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
